// File: rtl/tpu_operand_feeder.sv
// Operand feeder for tpu_core: buffers one A/B pair, streams K beats, captures C and drains it row by row.
// Optional WAIT watchdog is compiled in when TPU_FEEDER_WATCHDOG_EN is defined.
module tpu_operand_feeder #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int ACC_W     = 20,
    parameter int KMAX      = 16,
    parameter int WD_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [15:0]              cfg_k,
    output logic                     busy,
    output logic                     seq_done,
    output logic                     err,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     ld_sel,
    input  logic [$clog2(KMAX)-1:0]  ld_idx,
    input  logic [N*W-1:0]           ld_data,
    output logic                     core_start,
    output logic [15:0]              core_cfg_k,
    output logic                     core_in_valid,
    input  logic                     core_in_ready,
    output logic [N*W-1:0]           core_a_vec_flat,
    output logic [N*W-1:0]           core_b_vec_flat,
    input  logic                     core_done,
    input  logic [N*N*ACC_W-1:0]     core_C_flat,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N*ACC_W-1:0]       res_row,
    output logic [$clog2(N)-1:0]     res_idx,
    output logic                     res_last
);

    localparam int KW   = $clog2(KMAX);
    localparam int RW   = $clog2(N);
    localparam int VW   = N * W;
    localparam int ROWW = N * ACC_W;

    typedef enum logic [2:0] {IDLE, START, FEED, WAIT, DRAIN} state_t;

    state_t                 state;
    logic [VW-1:0]          abuf [KMAX];
    logic [VW-1:0]          bbuf [KMAX];
    logic [KW-1:0]          k;
    logic [KW-1:0]          k_next;
    logic [RW-1:0]          r;
    logic [VW-1:0]          a_vec;
    logic [VW-1:0]          b_vec;
    logic [N*N*ACC_W-1:0]   c_reg;
    logic                   load_en;
    logic                   go_legal;
    logic                   beat;
    logic                   last_beat;

`ifdef TPU_FEEDER_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0]         wd;
`endif

    assign load_en   = ld_valid && (state == IDLE);
    assign go_legal  = (cfg_k != 16'd0) && (cfg_k <= 16'(KMAX));
    assign beat      = core_in_valid && core_in_ready;
    assign last_beat = (16'(k) == (core_cfg_k - 16'd1));
    assign k_next    = k + KW'(1);

    // Buffer contents survive reset; only the load port writes them.
    always_ff @(posedge clk) begin
        if (load_en) begin
            if (ld_sel)
                bbuf[ld_idx] <= ld_data;
            else
                abuf[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            core_start    <= 1'b0;
            core_cfg_k    <= 16'd0;
            core_in_valid <= 1'b0;
            res_valid     <= 1'b0;
            seq_done      <= 1'b0;
            err           <= 1'b0;
            k             <= '0;
            r             <= '0;
`ifdef TPU_FEEDER_WATCHDOG_EN
            wd            <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            seq_done   <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (go_legal) begin
                            core_cfg_k <= cfg_k;
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                START: begin
                    k             <= '0;
                    a_vec         <= abuf[0];
                    b_vec         <= bbuf[0];
                    core_in_valid <= 1'b1;
                    state         <= FEED;
                end
                FEED: begin
                    if (beat) begin
                        if (last_beat) begin
                            core_in_valid <= 1'b0;
                            state         <= WAIT;
`ifdef TPU_FEEDER_WATCHDOG_EN
                            wd            <= '0;
`endif
                        end else begin
                            k     <= k_next;
                            a_vec <= abuf[k_next];
                            b_vec <= bbuf[k_next];
                        end
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        c_reg     <= core_C_flat;
                        r         <= '0;
                        res_valid <= 1'b1;
                        state     <= DRAIN;
                    end
`ifdef TPU_FEEDER_WATCHDOG_EN
                    else if (wd == WDW'(WD_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (r == RW'(N - 1)) begin
                            res_valid <= 1'b0;
                            seq_done  <= 1'b1;
                            r         <= '0;
                            state     <= IDLE;
                        end else begin
                            r <= r + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data registers are not reset, so every data output is gated by its valid.
    assign busy            = (state != IDLE);
    assign ld_ready        = (state == IDLE);
    assign core_a_vec_flat = core_in_valid ? a_vec : '0;
    assign core_b_vec_flat = core_in_valid ? b_vec : '0;
    assign res_idx         = r;
    assign res_row         = res_valid ? c_reg[int'(r)*ROWW +: ROWW] : '0;
    assign res_last        = res_valid && (r == RW'(N - 1));

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Directed bench for tpu_operand_feeder with a behavioural tpu_core accumulator model.
module tb_tpu_operand_feeder;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int ACC_W     = 20;
    localparam int KMAX      = 16;
    localparam int WD_CYCLES = 256;

    logic                  clk;
    logic                  rst;
    logic                  go;
    logic [15:0]           cfg_k;
    logic                  busy;
    logic                  seq_done;
    logic                  err;
    logic                  ld_valid;
    logic                  ld_ready;
    logic                  ld_sel;
    logic [3:0]            ld_idx;
    logic [N*W-1:0]        ld_data;
    logic                  core_start;
    logic [15:0]           core_cfg_k;
    logic                  core_in_valid;
    logic                  core_in_ready;
    logic [N*W-1:0]        core_a_vec_flat;
    logic [N*W-1:0]        core_b_vec_flat;
    logic                  core_done;
    logic [N*N*ACC_W-1:0]  core_C_flat;
    logic                  res_valid;
    logic                  res_ready;
    logic [N*ACC_W-1:0]    res_row;
    logic [1:0]            res_idx;
    logic                  res_last;

    int n_tests;
    int n_fail;

    tpu_operand_feeder #(
        .N(N), .W(W), .ACC_W(ACC_W), .KMAX(KMAX), .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .cfg_k(cfg_k), .busy(busy),
        .seq_done(seq_done), .err(err), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
        .core_start(core_start), .core_cfg_k(core_cfg_k),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_a_vec_flat(core_a_vec_flat), .core_b_vec_flat(core_b_vec_flat),
        .core_done(core_done), .core_C_flat(core_C_flat),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_idx(res_idx), .res_last(res_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: outer-product accumulation of every accepted beat.
    logic signed [ACC_W-1:0] acc [N][N];
    int beats;

    always @(posedge clk) begin
        if (rst || core_start) begin
            beats <= 0;
            for (int rr = 0; rr < N; rr++)
                for (int cc = 0; cc < N; cc++)
                    acc[rr][cc] <= '0;
        end else if (core_in_valid && core_in_ready) begin
            beats <= beats + 1;
            for (int rr = 0; rr < N; rr++)
                for (int cc = 0; cc < N; cc++)
                    acc[rr][cc] <= acc[rr][cc] + ACC_W'($signed(core_a_vec_flat[rr*W +: W]) *
                                                        $signed(core_b_vec_flat[cc*W +: W]));
        end
    end

    always_comb begin
        core_C_flat = '0;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++)
                core_C_flat[(rr*N+cc)*ACC_W +: ACC_W] = acc[rr][cc];
    end

    function automatic logic [N*W-1:0] pv(input int e0, input int e1, input int e2, input int e3);
        pv = {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    function automatic logic [N*ACC_W-1:0] pr(input int e0, input int e1, input int e2, input int e3);
        pr = {ACC_W'(e3), ACC_W'(e2), ACC_W'(e1), ACC_W'(e0)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int idx, input logic [N*W-1:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_idx   = 4'(idx);
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_go(input int kval);
        cfg_k = 16'(kval);
        go    = 1'b1;
        tick();
        go    = 1'b0;
    endtask

    logic [N*W-1:0]     acol [4];
    logic [N*W-1:0]     brow [4];
    logic [N*ACC_W-1:0] crow [4];
    int  cnt;
    logic seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; go = 1'b0; cfg_k = '0; ld_valid = 1'b0; ld_sel = 1'b0;
        ld_idx = '0; ld_data = '0; core_in_ready = 1'b0; core_done = 1'b0; res_ready = 1'b0;

        acol[0] = pv(1, -1, 5, 0); acol[1] = pv(2, 0, 6, 1);
        acol[2] = pv(3, 1, 7, 0);  acol[3] = pv(4, 2, 8, 1);
        brow[0] = pv(1, 0, 1, 0);  brow[1] = pv(2, -1, 0, 1);
        brow[2] = pv(3, 1, 2, 1);  brow[3] = pv(4, 0, -1, 2);
        crow[0] = pr(30, 1, 3, 13); crow[1] = pr(10, 1, -1, 5);
        crow[2] = pr(70, 1, 11, 29); crow[3] = pr(6, -1, -1, 3);

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ld_ready", 128'(ld_ready), 128'(1));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_in_valid", 128'(core_in_valid), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_seq_done", 128'(seq_done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_res_last", 128'(res_last), 128'(0));
        chk("rst_cfg_k", 128'(core_cfg_k), 128'(0));
        chk("rst_a_vec", 128'(core_a_vec_flat), 128'(0));
        chk("rst_res_row", 128'(res_row), 128'(0));
        chk("rst_res_idx", 128'(res_idx), 128'(0));

        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("idle_done_busy", 128'(busy), 128'(0));
        chk("idle_done_res_valid", 128'(res_valid), 128'(0));

        for (int i = 0; i < 4; i++) begin
            load(1'b0, i, acol[i]);
            load(1'b1, i, brow[i]);
        end

        // Full run, K = 4, no backpressure
        core_in_ready = 1'b1;
        res_ready     = 1'b1;
        do_go(4);
        chk("t1_core_start", 128'(core_start), 128'(1));
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_cfg_k", 128'(core_cfg_k), 128'(4));
        chk("t1_ld_ready", 128'(ld_ready), 128'(0));
        tick();
        chk("t1_start_pulse", 128'(core_start), 128'(0));
        for (int i = 0; i < 4; i++) begin
            chk("t1_in_valid", 128'(core_in_valid), 128'(1));
            chk("t1_a_vec", 128'(core_a_vec_flat), 128'(acol[i]));
            chk("t1_b_vec", 128'(core_b_vec_flat), 128'(brow[i]));
            tick();
        end
        chk("t1_wait_valid", 128'(core_in_valid), 128'(0));
        chk("t1_wait_a_zero", 128'(core_a_vec_flat), 128'(0));
        chk("t1_wait_b_zero", 128'(core_b_vec_flat), 128'(0));
        chk("t1_beats", 128'(beats), 128'(4));
        repeat (3) tick();
        chk("t1_wait_no_res", 128'(res_valid), 128'(0));
        chk("t1_beats_after", 128'(beats), 128'(4));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_res_valid", 128'(res_valid), 128'(1));
            chk("t1_res_idx", 128'(res_idx), 128'(i));
            chk("t1_res_last", 128'(res_last), 128'(i == 3));
            chk("t1_res_row", 128'(res_row), 128'(crow[i]));
            tick();
        end
        chk("t1_seq_done", 128'(seq_done), 128'(1));
        chk("t1_res_valid_drop", 128'(res_valid), 128'(0));
        chk("t1_busy_end", 128'(busy), 128'(0));
        tick();
        chk("t1_seq_done_pulse", 128'(seq_done), 128'(0));

        // Feed backpressure, K = 3, ready 1,0,0,1
        core_in_ready = 1'b0;
        do_go(3);
        tick();
        chk("t2_a0", 128'(core_a_vec_flat), 128'(acol[0]));
        core_in_ready = 1'b1;
        tick();
        chk("t2_a1", 128'(core_a_vec_flat), 128'(acol[1]));
        chk("t2_b1", 128'(core_b_vec_flat), 128'(brow[1]));
        core_in_ready = 1'b0;
        tick();
        chk("t2_a1_hold", 128'(core_a_vec_flat), 128'(acol[1]));
        chk("t2_valid_hold", 128'(core_in_valid), 128'(1));
        tick();
        chk("t2_a1_hold2", 128'(core_a_vec_flat), 128'(acol[1]));
        chk("t2_b1_hold2", 128'(core_b_vec_flat), 128'(brow[1]));
        core_in_ready = 1'b1;
        tick();
        chk("t2_a2", 128'(core_a_vec_flat), 128'(acol[2]));
        chk("t2_b2", 128'(core_b_vec_flat), 128'(brow[2]));
        tick();
        chk("t2_wait_valid", 128'(core_in_valid), 128'(0));
        chk("t2_wait_a_zero", 128'(core_a_vec_flat), 128'(0));
        chk("t2_wait_b_zero", 128'(core_b_vec_flat), 128'(0));
        chk("t2_beats", 128'(beats), 128'(3));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t2_row0", 128'(res_row), 128'(pr(14, 1, 7, 5)));
        tick();
        chk("t2_row1", 128'(res_row), 128'(pr(2, 1, 1, 1)));
        repeat (3) tick();
        chk("t2_seq_done", 128'(seq_done), 128'(1));
        tick();

        // Illegal K values
        do_go(0);
        chk("t3_err_k0", 128'(err), 128'(1));
        chk("t3_busy_k0", 128'(busy), 128'(0));
        chk("t3_start_k0", 128'(core_start), 128'(0));
        tick();
        chk("t3_err_k0_pulse", 128'(err), 128'(0));
        chk("t3_start_k0_late", 128'(core_start), 128'(0));
        do_go(17);
        chk("t3_err_k17", 128'(err), 128'(1));
        chk("t3_busy_k17", 128'(busy), 128'(0));
        chk("t3_start_k17", 128'(core_start), 128'(0));
        tick();
        chk("t3_err_k17_pulse", 128'(err), 128'(0));
        chk("t3_busy_k17_late", 128'(busy), 128'(0));

        // Drain backpressure, plus a go while busy
        res_ready = 1'b0;
        do_go(4);
        repeat (5) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bp_valid", 128'(res_valid), 128'(1));
            chk("t4_bp_idx", 128'(res_idx), 128'(0));
            chk("t4_bp_row", 128'(res_row), 128'(crow[0]));
            chk("t4_bp_err", 128'(err), 128'(0));
            go = (i == 2);
            tick();
        end
        go = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_res_idx", 128'(res_idx), 128'(i));
            chk("t4_res_row", 128'(res_row), 128'(crow[i]));
            tick();
        end
        chk("t4_seq_done", 128'(seq_done), 128'(1));
        tick();

        // Reset after beat 1, then rerun with retained buffers
        do_go(4);
        repeat (3) tick();
        chk("t5_pre_rst_beats", 128'(beats), 128'(2));
        rst = 1'b1;
        tick();
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_in_valid", 128'(core_in_valid), 128'(0));
        chk("t5_ld_ready", 128'(ld_ready), 128'(1));
        chk("t5_a_zero", 128'(core_a_vec_flat), 128'(0));
        rst = 1'b0;
        tick();
        do_go(4);
        repeat (5) tick();
        chk("t5_beats", 128'(beats), 128'(4));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_res_row", 128'(res_row), 128'(crow[i]));
            tick();
        end
        chk("t5_seq_done", 128'(seq_done), 128'(1));
        tick();

        // core_done withheld
        do_go(4);
        repeat (5) tick();
        cnt  = 0;
        seen = 1'b0;
`ifdef TPU_FEEDER_WATCHDOG_EN
        while (!err && cnt < 400) begin
            if (res_valid) seen = 1'b1;
            tick();
            cnt++;
        end
        chk("t6_wd_cycles", 128'(cnt), 128'(WD_CYCLES));
        chk("t6_wd_busy", 128'(busy), 128'(0));
        chk("t6_wd_res_valid", 128'(res_valid), 128'(0));
        chk("t6_wd_seen_res", 128'(seen), 128'(0));
        tick();
        chk("t6_wd_err_pulse", 128'(err), 128'(0));
        chk("t6_wd_no_seq_done", 128'(seq_done), 128'(0));
        chk("t6_wd_idle", 128'(busy), 128'(0));
`else
        while (cnt < 300) begin
            if (err || res_valid || !busy) seen = 1'b1;
            tick();
            cnt++;
        end
        chk("t6_hold_seen", 128'(seen), 128'(0));
        chk("t6_hold_busy", 128'(busy), 128'(1));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (3) tick();
        chk("t6_hold_row3", 128'(res_row), 128'(crow[3]));
        chk("t6_hold_last", 128'(res_last), 128'(1));
        tick();
        chk("t6_hold_seq_done", 128'(seq_done), 128'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
